// File: rtl/mc_pipe_sequencer.sv
// Issue/hazard sequencer for the 4-stage microcoded datapath (S0..S3), plus the
// microcode field accessors. Optional macro MC_BYPASS_EN drops S3 from the hazard compare.

package microcode;
    localparam int WIDTH = 25;

    // Control flags live in the low bits; [24:6] is opaque datapath payload.
    function automatic logic mcs0_check_rs1_dep(input logic [WIDTH-1:0] mc);
        return mc[0];
    endfunction
    function automatic logic mcs0_check_rs2_dep(input logic [WIDTH-1:0] mc);
        return mc[1];
    endfunction
    function automatic logic mcs1_mem_in_use(input logic [WIDTH-1:0] mc);
        return mc[2];
    endfunction
    function automatic logic mcs2_alu_out_over_pc(input logic [WIDTH-1:0] mc);
        return mc[3];
    endfunction
    function automatic logic mcs2_jump_if_cmp(input logic [WIDTH-1:0] mc);
        return mc[4];
    endfunction
    function automatic logic mcs3_reg_we(input logic [WIDTH-1:0] mc);
        return mc[5];
    endfunction
endpackage

module mc_pipe_sequencer
    import microcode::*;
#(
    parameter int REG_AW   = 5,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [WIDTH-1:0]    issue_mc,
    input  logic [REG_AW-1:0]   issue_rs1,
    input  logic [REG_AW-1:0]   issue_rs2,
    input  logic [REG_AW-1:0]   issue_rd,
    input  logic                mem_busy,
    input  logic                cmp_true,
    output logic [3:0]          stage_valid,
    output logic [WIDTH-1:0]    s0_mc,
    output logic [WIDTH-1:0]    s1_mc,
    output logic [WIDTH-1:0]    s2_mc,
    output logic [WIDTH-1:0]    s3_mc,
    output logic [REG_AW-1:0]   s3_rd,
    output logic                flush,
    output logic [STALL_CW-1:0] stall_cycles
);

`ifdef MC_BYPASS_EN
    localparam int HAZ_STAGES = 3;
`else
    localparam int HAZ_STAGES = 4;
`endif

    logic [3:0]          r_vld;
    logic [WIDTH-1:0]    r_mc [0:3];
    logic [REG_AW-1:0]   r_rd [0:3];
    logic                r_flush;
    logic [STALL_CW-1:0] r_stall_cnt;

    logic w_mem_stall;
    logic w_jump;
    logic w_dep_hazard;
    logic w_ready;
    logic w_accept;

    assign w_mem_stall = r_vld[2] && mcs1_mem_in_use(r_mc[2]) && mem_busy;
    assign w_jump      = r_vld[2] && !w_mem_stall &&
                         (mcs2_alu_out_over_pc(r_mc[2]) || (mcs2_jump_if_cmp(r_mc[2]) && cmp_true));

    // A producer with rd==0 is skipped, which also covers the rs==0 exemption.
    always_comb begin
        w_dep_hazard = 1'b0;
        for (int i = 0; i < HAZ_STAGES; i++) begin
            if (r_vld[i] && mcs3_reg_we(r_mc[i]) && (r_rd[i] != '0)) begin
                if (mcs0_check_rs1_dep(issue_mc) && (issue_rs1 == r_rd[i]))
                    w_dep_hazard = 1'b1;
                if (mcs0_check_rs2_dep(issue_mc) && (issue_rs2 == r_rd[i]))
                    w_dep_hazard = 1'b1;
            end
        end
    end

    assign w_ready  = !w_mem_stall && !w_dep_hazard && !w_jump;
    assign w_accept = issue_valid && w_ready;
    // rst_n only gates the port so the async reset net never reaches flop data.
    assign issue_ready = rst_n && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld       <= '0;
            r_flush     <= 1'b0;
            r_stall_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                r_mc[i] <= '0;
                r_rd[i] <= '0;
            end
        end else begin
            r_flush <= w_jump;
            if (issue_valid && !w_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + STALL_CW'(1);

            if (w_mem_stall) begin
                r_vld[3] <= 1'b0;
                r_mc[3]  <= '0;
                r_rd[3]  <= '0;
            end else begin
                r_vld[3] <= r_vld[2];
                r_mc[3]  <= r_mc[2];
                r_rd[3]  <= r_rd[2];
                // Words moving into S1/S2 are the wrong-path ones on a taken jump.
                r_vld[2] <= r_vld[1] && !w_jump;
                r_mc[2]  <= w_jump ? '0 : r_mc[1];
                r_rd[2]  <= w_jump ? '0 : r_rd[1];
                r_vld[1] <= r_vld[0] && !w_jump;
                r_mc[1]  <= w_jump ? '0 : r_mc[0];
                r_rd[1]  <= w_jump ? '0 : r_rd[0];
                r_vld[0] <= w_accept;
                r_mc[0]  <= w_accept ? issue_mc : '0;
                r_rd[0]  <= w_accept ? issue_rd : '0;
            end
        end
    end

    assign stage_valid  = r_vld;
    assign s0_mc        = r_mc[0];
    assign s1_mc        = r_mc[1];
    assign s2_mc        = r_mc[2];
    assign s3_mc        = r_mc[3];
    assign s3_rd        = r_rd[3];
    assign flush        = r_flush;
    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_mc_pipe_sequencer.sv
// Bench for mc_pipe_sequencer: stage-list reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_mc_pipe_sequencer;
    localparam int W   = 25;
    localparam int AW  = 5;
    localparam int SCW = 6;
`ifdef MC_BYPASS_EN
    localparam int NCHK = 3, EXP_ST = 3;
`else
    localparam int NCHK = 4, EXP_ST = 4;
`endif
    localparam logic [5:0] F_C1 = 6'h01, F_C2 = 6'h02, F_MEM = 6'h04,
                           F_PC = 6'h08, F_JIF = 6'h10, F_WE = 6'h20;

    logic           clk, rst_n, issue_valid, issue_ready, mem_busy, cmp_true, flush;
    logic [W-1:0]   issue_mc, s0_mc, s1_mc, s2_mc, s3_mc;
    logic [AW-1:0]  issue_rs1, issue_rs2, issue_rd, s3_rd;
    logic [3:0]     stage_valid;
    logic [SCW-1:0] stall_cycles;

    mc_pipe_sequencer #(.REG_AW(AW), .STALL_CW(SCW)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_mc(issue_mc), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .mem_busy(mem_busy), .cmp_true(cmp_true), .stage_valid(stage_valid),
        .s0_mc(s0_mc), .s1_mc(s1_mc), .s2_mc(s2_mc), .s3_mc(s3_mc), .s3_rd(s3_rd),
        .flush(flush), .stall_cycles(stall_cycles));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit v; logic [W-1:0] mc; logic [AW-1:0] rd; } stg_t;
    stg_t m [4];
    bit   m_flush;
    int   m_stall;
    int   nvec, nerr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mkw(input logic [5:0] fl, input logic [18:0] pl);
        return {pl, fl};
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 4; i++) m[i] = '{v: 1'b0, mc: '0, rd: '0};
        m_flush = 1'b0;
        m_stall = 0;
    endtask

    // Outcome of the current cycle from the issue rules applied to the stage list.
    task automatic m_eval(output bit ms, output bit jmp, output bit rdy);
        bit haz;
        haz = 1'b0;
        ms  = m[2].v && m[2].mc[2] && mem_busy;
        jmp = m[2].v && !ms && (m[2].mc[3] || (m[2].mc[4] && cmp_true));
        for (int i = 0; i < NCHK; i++)
            if (m[i].v && m[i].mc[5] && m[i].rd != 0) begin
                if (issue_mc[0] && issue_rs1 != 0 && issue_rs1 == m[i].rd) haz = 1'b1;
                if (issue_mc[1] && issue_rs2 != 0 && issue_rs2 == m[i].rd) haz = 1'b1;
            end
        rdy = rst_n && !ms && !haz && !jmp;
    endtask

    task automatic compare();
        bit ms, jmp, rdy;
        m_eval(ms, jmp, rdy);
        chk("issue_ready", issue_ready, rdy);
        chk("stage_valid", stage_valid, {m[3].v, m[2].v, m[1].v, m[0].v});
        chk("s0_mc", s0_mc, m[0].v ? m[0].mc : '0);
        chk("s1_mc", s1_mc, m[1].v ? m[1].mc : '0);
        chk("s2_mc", s2_mc, m[2].v ? m[2].mc : '0);
        chk("s3_mc", s3_mc, m[3].v ? m[3].mc : '0);
        chk("s3_rd", s3_rd, m[3].v ? m[3].rd : '0);
        chk("flush", flush, m_flush);
        chk("stall_cycles", stall_cycles, m_stall);
    endtask

    task automatic m_update();
        bit ms, jmp, rdy;
        if (!rst_n) begin
            m_clear();
            return;
        end
        m_eval(ms, jmp, rdy);
        if (issue_valid && !rdy && m_stall < (1 << SCW) - 1) m_stall++;
        m_flush = jmp;
        if (ms) begin
            m[3] = '{v: 1'b0, mc: '0, rd: '0};
        end else begin
            m[3] = m[2];
            m[2] = m[1];
            m[1] = m[0];
            if (jmp) begin
                m[1].v = 1'b0;
                m[2].v = 1'b0;
            end
            if (issue_valid && rdy) m[0] = '{v: 1'b1, mc: issue_mc, rd: issue_rd};
            else                    m[0] = '{v: 1'b0, mc: '0, rd: '0};
        end
    endtask

    task automatic step();
        #1 compare();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic set_in(input bit v, input logic [W-1:0] mc, input int rs1, input int rs2,
                          input int rd, input bit busy, input bit cmp);
        issue_valid = v;
        issue_mc    = mc;
        issue_rs1   = AW'(rs1);
        issue_rs2   = AW'(rs2);
        issue_rd    = AW'(rd);
        mem_busy    = busy;
        cmp_true    = cmp;
    endtask

    task automatic idle(input int n);
        set_in(0, '0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    logic [W-1:0] wa, wb, wc, wd, wj, wm, wp, wq;
    int st0;

    initial begin
        nvec = 0; nerr = 0;
        m_clear();
        wa = mkw(6'h00, 19'h0A1); wb = mkw(6'h00, 19'h0B2);
        wc = mkw(6'h00, 19'h0C3); wd = mkw(6'h00, 19'h0D4);

        // Reset with a word already offered.
        rst_n = 1'b0;
        set_in(1, wa, 1, 2, 3, 0, 0);
        @(posedge clk); #1;
        chk("rst_stage_valid", stage_valid, 4'b0000);
        chk("rst_issue_ready", issue_ready, 1'b0);
        chk("rst_stall_cycles", stall_cycles, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("fill1", stage_valid, 4'b0001);
        set_in(1, wb, 0, 0, 0, 0, 0); step(); chk("fill2", stage_valid, 4'b0011);
        set_in(1, wc, 0, 0, 0, 0, 0); step(); chk("fill3", stage_valid, 4'b0111);
        set_in(1, wd, 0, 0, 0, 0, 0); step(); chk("fill4", stage_valid, 4'b1111);
        chk("fill4_s3_mc", s3_mc, wa);
        idle(4);

        // Read-after-write dependency on r5.
        wp = mkw(F_WE, 19'h111); wq = mkw(F_C1, 19'h222);
        set_in(1, wp, 0, 0, 5, 0, 0); step();
        st0 = int'(stall_cycles);
        set_in(1, wq, 5, 0, 0, 0, 0);
        repeat (EXP_ST + 1) step();
        chk("dep_stall_count", int'(stall_cycles) - st0, EXP_ST);
        chk("dep_accepted", s0_mc, wq);
        idle(5);

        // rs1=0 behind an rd=0 writer is never a hazard.
        set_in(1, mkw(F_WE, 19'h333), 0, 0, 0, 0, 0); step();
        set_in(1, wq, 0, 0, 0, 0, 0);
        #1 chk("rs1_zero_ready", issue_ready, 1'b1);
        step();
        idle(4);

        // Conditional jump in S2, taken then not taken.
        wj = mkw(F_JIF, 19'h444);
        for (int t = 1; t >= 0; t--) begin
            set_in(1, wj, 0, 0, 0, 0, 0); step();
            set_in(1, wa, 0, 0, 0, 0, 0); step();
            set_in(1, wb, 0, 0, 0, 0, 0); step();
            set_in(1, wc, 0, 0, 0, 0, t[0]);
            #1 chk("jmp_ready", issue_ready, !t[0]);
            step();
            chk("jmp_flush", flush, t[0]);
            chk("jmp_stage_valid", stage_valid, t[0] ? 4'b1000 : 4'b1111);
            chk("jmp_s3_mc", s3_mc, wj);
            idle(4);
        end

        // Memory word that also redirects the PC, held off by mem_busy.
        wm = mkw(F_MEM | F_PC, 19'h555);
        set_in(1, wm, 0, 0, 0, 0, 0); step();
        set_in(1, wa, 0, 0, 0, 0, 0); step();
        set_in(1, wb, 0, 0, 0, 0, 0); step();
        repeat (3) begin
            set_in(1, wc, 0, 0, 0, 1, 0); step();
            chk("mem_stage_valid", stage_valid, 4'b0111);
            chk("mem_no_flush", flush, 1'b0);
            chk("mem_s2_frozen", s2_mc, wm);
        end
        set_in(1, wc, 0, 0, 0, 0, 0);
        #1 chk("mem_release_ready", issue_ready, 1'b0);
        step();
        chk("mem_release_flush", flush, 1'b1);
        chk("mem_release_valid", stage_valid, 4'b1000);
        chk("mem_release_s3", s3_mc, wm);

        // Reset in the middle of traffic.
        set_in(1, wa, 0, 0, 0, 0, 0); step(); step(); step();
        rst_n = 1'b0;
        m_clear();
        #1;
        chk("midrst_valid", stage_valid, 4'b0000);
        chk("midrst_s3_mc", s3_mc, '0);
        chk("midrst_ready", issue_ready, 1'b0);
        step(); step();
        rst_n = 1'b1;

        // Random traffic with a small register range to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            logic [5:0] fl;
            fl = 6'($urandom) & (F_C1 | F_C2 | F_MEM | F_WE);
            if ($urandom_range(0, 15) == 0) fl |= F_PC;
            if ($urandom_range(0, 7) == 0)  fl |= F_JIF;
            set_in($urandom_range(0, 3) != 0, mkw(fl, 19'($urandom)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                m_clear();
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
